fifo_read_adapter: RTL and testbench

FIFO_READ_ADAPTER -- requirements
Module: fifo_read_adapter

---
 rtl/fifo_read_adapter.sv | 112 +++++++++++
 tb/tb_fifo_read_adapter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_read_adapter.sv
// fifo_read_adapter: turns a FIFO with one-cycle read latency into a
// valid/ready stream. A 3-entry circular skid buffer absorbs the word that is
// already in flight when the consumer stalls, so fifo_rd_en never depends on
// m_ready and the adapter still sustains one word per cycle.
module fifo_read_adapter #(
    parameter int FIFO_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_rd_en,
    input  logic                  flush,
    output logic                  m_valid,
    output logic [FIFO_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic [15:0]           rd_count,
    output logic                  err_underflow
);

    logic [FIFO_WIDTH-1:0] buf_r [0:2];
    logic [1:0]            wr_ptr_r;
    logic [1:0]            rd_ptr_r;
    logic [1:0]            occ_r;
    logic                  pend_r;
    logic [15:0]           rd_count_r;
    logic                  err_underflow_r;

    logic [2:0]            fill_s;
    logic                  capture_s;
    logic                  handshake_s;
    logic [1:0]            occ_next_s;

    // Circular pointer step over the three buffer slots: 0 -> 1 -> 2 -> 0.
    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        logic [1:0] n;
        case (p)
            2'd0:    n = 2'd1;
            2'd1:    n = 2'd2;
            default: n = 2'd0;
        endcase
        return n;
    endfunction

    // Read request, stream handshake and next-occupancy decode; the in-flight
    // word counts against capacity so a stall can never overrun the buffer.
    always_comb begin
        fill_s      = {1'b0, occ_r} + {2'b00, pend_r};
        fifo_rd_en  = rst_n && !flush && !fifo_empty && (fill_s < 3'd3);
        m_valid     = rst_n && !flush && (occ_r != 2'd0);
        capture_s   = pend_r && !flush;
        handshake_s = m_valid && m_ready;
        case ({capture_s, handshake_s})
            2'b10:   occ_next_s = occ_r + 2'd1;
            2'b01:   occ_next_s = occ_r - 2'd1;
            default: occ_next_s = occ_r;
        endcase
    end

    // Head-of-buffer select for the stream data.
    always_comb begin
        case (rd_ptr_r)
            2'd0:    m_data = buf_r[0];
            2'd1:    m_data = buf_r[1];
            2'd2:    m_data = buf_r[2];
            default: m_data = {FIFO_WIDTH{1'b0}};
        endcase
    end

    // Buffer, pointers, occupancy, in-flight tracking, counter and sticky error.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                buf_r[i] <= {FIFO_WIDTH{1'b0}};
            end
            wr_ptr_r        <= 2'd0;
            rd_ptr_r        <= 2'd0;
            occ_r           <= 2'd0;
            pend_r          <= 1'b0;
            rd_count_r      <= 16'd0;
            err_underflow_r <= 1'b0;
        end else if (flush) begin
            wr_ptr_r        <= 2'd0;
            rd_ptr_r        <= 2'd0;
            occ_r           <= 2'd0;
            pend_r          <= 1'b0;
            err_underflow_r <= err_underflow_r | fifo_underflow;
        end else begin
            pend_r <= fifo_rd_en;
            if (capture_s) begin
                buf_r[wr_ptr_r] <= fifo_data_out;
                wr_ptr_r        <= ptr_inc(wr_ptr_r);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (handshake_s) begin
                rd_ptr_r   <= ptr_inc(rd_ptr_r);
                rd_count_r <= rd_count_r + 16'd1;
            end else begin
                rd_ptr_r   <= rd_ptr_r;
                rd_count_r <= rd_count_r;
            end
            occ_r           <= occ_next_s;
            err_underflow_r <= err_underflow_r | fifo_underflow;
        end
    end

    assign rd_count      = rd_count_r;
    assign err_underflow = err_underflow_r;

endmodule

// File: tb/tb_fifo_read_adapter.sv
// Testbench for fifo_read_adapter: a queue-based FIFO source and a queue-based
// reference of the adapter's buffered contents are stepped once per clock.
module tb_fifo_read_adapter;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n, fifo_empty, fifo_underflow, flush, m_ready;
    logic [W-1:0] fifo_data_out, m_data;
    logic         fifo_rd_en, m_valid, err_underflow;
    logic [15:0]  rd_count;

    always #5 clk = ~clk;

    fifo_read_adapter #(.FIFO_WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty),
        .fifo_underflow(fifo_underflow), .fifo_data_out(fifo_data_out),
        .fifo_rd_en(fifo_rd_en), .flush(flush), .m_valid(m_valid),
        .m_data(m_data), .m_ready(m_ready), .rd_count(rd_count),
        .err_underflow(err_underflow)
    );

    logic [W-1:0] fq[$];      // contents of the upstream FIFO
    logic [W-1:0] sb[$];      // words the adapter should be holding, head first
    logic [W-1:0] out_q[$];   // words actually delivered on the stream
    bit           inflight;
    logic [W-1:0] inflight_word;
    logic [15:0]  m_count;
    bit           m_err;
    logic [W-1:0] next_word;
    logic [W-1:0] base;
    int n_cmp, n_fail, cyc, rd_pulses, first_rd, first_val, last_val;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) begin
            fq.push_back(next_word);
            next_word = next_word + 16'd1;
        end
        fifo_empty = (fq.size() == 0);
    endtask

    // One clock: check outputs against the reference, advance reference and FIFO.
    task automatic cycle();
        logic e_rd, e_val, hs, rd_now;
        #1;
        e_rd  = rst_n && !flush && !fifo_empty && ((sb.size() + int'(inflight)) < 3);
        e_val = rst_n && !flush && (sb.size() != 0);
        chk("fifo_rd_en", 32'(fifo_rd_en), 32'(e_rd));
        chk("m_valid", 32'(m_valid), 32'(e_val));
        if (e_val) chk("m_data", 32'(m_data), 32'(sb[0]));
        chk("rd_count", 32'(rd_count), 32'(m_count));
        chk("err_underflow", 32'(err_underflow), 32'(m_err));
        hs     = e_val && m_ready;
        rd_now = fifo_rd_en;
        if (rd_now) begin
            rd_pulses++;
            if (first_rd < 0) first_rd = cyc;
        end
        if (m_valid) begin
            if (first_val < 0) first_val = cyc;
            last_val = cyc;
        end
        if (m_valid && m_ready) out_q.push_back(m_data);
        if (!rst_n) begin
            sb.delete();
            inflight = 1'b0;
            m_count  = 16'd0;
            m_err    = 1'b0;
        end else begin
            if (flush) begin
                sb.delete();
            end else begin
                if (hs) begin
                    void'(sb.pop_front());
                    m_count = m_count + 16'd1;
                end
                if (inflight) sb.push_back(inflight_word);
            end
            if (fifo_underflow) m_err = 1'b1;
            inflight = e_rd;
        end
        @(posedge clk);
        #1;
        if (rd_now && fq.size() != 0) fifo_data_out = fq.pop_front();
        else fifo_data_out = W'($urandom);
        inflight_word = fifo_data_out;
        fifo_empty    = (fq.size() == 0);
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        n_cmp = 0; n_fail = 0; cyc = 0; rd_pulses = 0;
        first_rd = -1; first_val = -1; last_val = -1;
        rst_n = 1'b0; flush = 1'b0; m_ready = 1'b0; fifo_empty = 1'b1;
        fifo_underflow = 1'b0; fifo_data_out = 16'd0;
        inflight = 1'b0; inflight_word = 16'd0; m_count = 16'd0; m_err = 1'b0;
        next_word = 16'd1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        cycle();
        chk("reset_m_data", 32'(m_data), 32'd0);
        chk("reset_rd_count", 32'(rd_count), 32'd0);
        rst_n = 1'b1;

        // Streaming: 8 preloaded words, consumer always ready.
        base = next_word; push_words(8); m_ready = 1'b1;
        out_q.delete(); first_rd = -1; first_val = -1;
        for (int i = 0; i < 24 && out_q.size() < 8; i++) cycle();
        chk("stream_count", 32'(out_q.size()), 32'd8);
        chk("stream_latency", 32'(first_val - first_rd), 32'd2);
        chk("stream_back_to_back", 32'(last_val - first_val), 32'd7);
        for (int i = 0; i < 8; i++) chk("stream_word", 32'(out_q[i]), 32'(base + W'(i)));
        chk("stream_rd_count", 32'(rd_count), 32'd8);

        // Backpressure: consumer stalled, buffer fills to 3 and holds the head.
        base = next_word; push_words(6); m_ready = 1'b0;
        out_q.delete(); rd_pulses = 0;
        repeat (8) cycle();
        chk("bp_rd_pulses", 32'(rd_pulses), 32'd3);
        chk("bp_m_valid", 32'(m_valid), 32'd1);
        chk("bp_m_data_held", 32'(m_data), 32'(base));
        m_ready = 1'b1;
        for (int i = 0; i < 30 && out_q.size() < 6; i++) cycle();
        chk("bp_count", 32'(out_q.size()), 32'd6);
        for (int i = 0; i < 6; i++) chk("bp_word", 32'(out_q[i]), 32'(base + W'(i)));

        // Wrap-around: ready toggles every cycle.
        base = next_word; push_words(10); out_q.delete();
        for (int i = 0; i < 80 && out_q.size() < 10; i++) begin
            m_ready = ((i % 2) == 1);
            cycle();
        end
        chk("wrap_count", 32'(out_q.size()), 32'd10);
        for (int i = 0; i < 10; i++) chk("wrap_word", 32'(out_q[i]), 32'(base + W'(i)));

        // Flush with two buffered words and one in flight.
        m_ready = 1'b0; base = next_word; push_words(4);
        repeat (3) cycle();
        flush = 1'b1;
        #1;
        chk("flush_m_valid", 32'(m_valid), 32'd0);
        chk("flush_rd_en", 32'(fifo_rd_en), 32'd0);
        cycle();
        flush = 1'b0; m_ready = 1'b1; out_q.delete();
        for (int i = 0; i < 12 && out_q.size() < 1; i++) cycle();
        repeat (3) cycle();
        chk("flush_count", 32'(out_q.size()), 32'd1);
        chk("flush_next_word", 32'(out_q[0]), 32'(base + 16'd3));

        // Counter wrap from 0xFFFF.
        force dut.rd_count_r = 16'hFFFF;
        #1;
        release dut.rd_count_r;
        m_count = 16'hFFFF;
        push_words(1); out_q.delete();
        for (int i = 0; i < 12 && out_q.size() < 1; i++) cycle();
        chk("count_wrap", 32'(rd_count), 32'd0);

        // Sticky underflow error survives flush, cleared by reset.
        fifo_underflow = 1'b1; cycle(); fifo_underflow = 1'b0; cycle();
        chk("err_set", 32'(err_underflow), 32'd1);
        flush = 1'b1; cycle(); flush = 1'b0; cycle();
        chk("err_after_flush", 32'(err_underflow), 32'd1);
        rst_n = 1'b0; cycle(); rst_n = 1'b1;
        chk("err_after_reset", 32'(err_underflow), 32'd0);

        // Reset mid-stream with two buffered words and one in flight.
        m_ready = 1'b0; base = next_word; push_words(4);
        repeat (3) cycle();
        rst_n = 1'b0;
        #1;
        chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        cycle();
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_rd_count", 32'(rd_count), 32'd0);
        rst_n = 1'b1; m_ready = 1'b1; out_q.delete();
        for (int i = 0; i < 12 && out_q.size() < 1; i++) cycle();
        repeat (3) cycle();
        chk("rst_count", 32'(out_q.size()), 32'd1);
        chk("rst_next_word", 32'(out_q[0]), 32'(base + 16'd3));

        // Randomized traffic with occasional flush, underflow and reset.
        for (int i = 0; i < 400; i++) begin
            m_ready = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 3) == 0) push_words(int'($urandom_range(1, 3)));
            flush          = ($urandom_range(0, 19) == 0);
            fifo_underflow = ($urandom_range(0, 49) == 0);
            rst_n          = ($urandom_range(0, 99) != 0);
            cycle();
        end
        flush = 1'b0; fifo_underflow = 1'b0; rst_n = 1'b1; m_ready = 1'b1;
        repeat (40) cycle();
        chk("random_drained", 32'(m_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
